// File: rtl/serial_borrow_look_ahead_subtractor_pkg.sv
// Shared definitions for the serial borrow look-ahead subtractor:
// FSM state encoding, slice width and the per-bit borrow generate/propagate helper.
package serial_borrow_look_ahead_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int SLICE_BITS = 2;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // A borrow is generated when a=0,b=1 and passes through unchanged when a==b.
  function automatic gp_t bit_gp(input logic a, input logic b);
    gp_t r;
    r.g = ~a & b;
    r.p = ~(a ^ b);
    return r;
  endfunction

endpackage

// File: rtl/two_bit_borrow_look_ahead.sv
// Combinational two-bit subtract slice with borrow look-ahead; exports the
// group propagate/generate terms alongside the slice borrow-out.
module two_bit_borrow_look_ahead
  import serial_borrow_look_ahead_subtractor_pkg::*;
(
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  input  logic       bin_i,
  output logic [1:0] d_o,
  output logic       bout_o,
  output logic       p_o,
  output logic       g_o
);

  gp_t  gp0;
  gp_t  gp1;
  logic bw1;

  assign gp0 = bit_gp(a_i[0], b_i[0]);
  assign gp1 = bit_gp(a_i[1], b_i[1]);

  assign bw1    = gp0.g | (gp0.p & bin_i);
  assign d_o[0] = a_i[0] ^ b_i[0] ^ bin_i;
  assign d_o[1] = a_i[1] ^ b_i[1] ^ bw1;

  assign g_o    = gp1.g | (gp1.p & gp0.g);
  assign p_o    = gp1.p & gp0.p;
  assign bout_o = g_o | (p_o & bin_i);

endmodule

// File: rtl/serial_borrow_look_ahead_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, two bits per clock through one
// shared look-ahead slice, with a start/busy/done handshake.
module serial_borrow_look_ahead_subtractor
  import serial_borrow_look_ahead_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE_BITS;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

  if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("serial_borrow_look_ahead_subtractor: WIDTH must be even and >= 2");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             bw_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             zero_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic [1:0]       sl_a;
  logic [1:0]       sl_b;
  logic [1:0]       sl_d;
  logic             sl_bout;
  logic             sl_p;
  logic             sl_g;
  logic [WIDTH-1:0] res_d;
  logic             grp_unused;

  // One slice serves every bit pair; cnt selects which pair it sees this cycle.
  always_comb begin
    sl_a = a_q[cnt_q*SLICE_BITS +: SLICE_BITS];
    sl_b = b_q[cnt_q*SLICE_BITS +: SLICE_BITS];
  end

  two_bit_borrow_look_ahead u_slice (
    .a_i    (sl_a),
    .b_i    (sl_b),
    .bin_i  (bw_q),
    .d_o    (sl_d),
    .bout_o (sl_bout),
    .p_o    (sl_p),
    .g_o    (sl_g)
  );

  assign grp_unused = sl_p ^ sl_g;

  always_comb begin
    res_d = res_q;
    res_d[cnt_q*SLICE_BITS +: SLICE_BITS] = sl_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      bw_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            bw_q    <= bin;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          res_q <= res_d;
          bw_q  <= sl_bout;
          if (cnt_q == CNT_LAST) begin
            diff_q  <= res_d;
            bout_q  <= sl_bout;
            zero_q  <= (res_d == '0);
            ovf_q   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_borrow_look_ahead_subtractor.sv
// Scoreboard bench for the serial subtractor: the driver pushes arithmetic
// reference results, a negedge monitor pops and compares on every done pulse.
module tb_serial_borrow_look_ahead_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         zero;
  logic         ovf;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];
  exp_t last;
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  serial_borrow_look_ahead_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .zero  (zero),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic bi);
    logic [W:0] full;
    exp_t       e;
    full   = {1'b0, aa} - {1'b0, bb} - (W+1)'(bi);
    e.diff = full[W-1:0];
    e.bout = full[W];
    e.zero = (e.diff == '0);
    e.ovf  = (aa[W-1] != bb[W-1]) && (e.diff[W-1] != aa[W-1]);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("res_diff", 32'(diff), 32'(mon_e.diff));
        chk("res_bout", 32'(bout), 32'(mon_e.bout));
        chk("res_zero", 32'(zero), 32'(mon_e.zero));
        chk("res_ovf",  32'(ovf),  32'(mon_e.ovf));
      end
    end
  end

  // Called just after an edge with the DUT in IDLE or DONE; returns in the done cycle.
  task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic bi, input bit poke);
    exp_t e;
    e     = model(aa, bb, bi);
    a     = aa;
    b     = bb;
    bin   = bi;
    start = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < W/2; i++) begin
      chk("busy_run",  32'(busy), 32'(1));
      chk("done_run",  32'(done), 32'(0));
      chk("diff_hold", 32'(diff), 32'(last.diff));
      chk("bout_hold", 32'(bout), 32'(last.bout));
      if (poke && i == 2) begin
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h00;
        bin   = 1'b0;
      end else if (poke && i == 3) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk("done_pulse", 32'(done), 32'(1));
    chk("busy_done",  32'(busy), 32'(0));
    last = e;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      chk("idle_done", 32'(done), 32'(0));
      chk("idle_busy", 32'(busy), 32'(0));
      chk("idle_diff", 32'(diff), 32'(last.diff));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
    chk({tag, "_diff"}, 32'(diff), 32'(0));
    chk({tag, "_bout"}, 32'(bout), 32'(0));
    chk({tag, "_zero"}, 32'(zero), 32'(0));
    chk({tag, "_ovf"},  32'(ovf),  32'(0));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    last  = '{diff: '0, bout: 1'b0, zero: 1'b0, ovf: 1'b0};
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    idle(1);

    run_op(8'h35, 8'h12, 1'b0, 1'b0);
    run_op(8'h12, 8'h35, 1'b0, 1'b0);
    idle(1);
    run_op(8'h80, 8'h01, 1'b0, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 1'b0);
    run_op(8'h50, 8'h50, 1'b0, 1'b0);
    idle(2);
    run_op(8'h35, 8'h12, 1'b0, 1'b1);
    run_op(8'h10, 8'h01, 1'b0, 1'b0);
    idle(1);

    // Reset landing between edges in the middle of an operation.
    a     = 8'h77;
    b     = 8'h11;
    bin   = 1'b0;
    start = 1'b1;
    sb_q.push_back(model(8'h77, 8'h11, 1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    void'(sb_q.pop_back());
    last = '{diff: '0, bout: 1'b0, zero: 1'b0, ovf: 1'b0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    run_op(8'h77, 8'h11, 1'b0, 1'b0);
    idle(1);

    for (int k = 0; k < 40; k++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      idle($urandom_range(0, 2));
    end

    idle(2);
    chk("sb_empty", 32'(sb_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
